load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Load/store unit between the core datapath (ALU address, register-file store data, write-back mux) and the single-port data memory.
- Accepts one memory request at a time.
- Formats loads with sign or zero extension.
- Performs sub-word stores as read-modify-write, because the data memory has a single whole-word write enable and no byte enables.
- Flags misaligned and illegal accesses.
- Stalls the core while busy.

Parameters:
MEM_ADDR_BITS, 9, word-address width of the data memory.
DATA_WIDTH, 32, data path width; only 32 is supported.

Ports:
clk  in  1  clock, rising edge.
Reset  in  1  synchronous, active-high reset.
ReqValid  in  1  core presents a load/store request.
ReqReady  out  1  unit can accept; high only in IDLE.
ReqStore  in  1  1=store, 0=load.
ReqFunct3  in  3  RISC-V funct3: loads 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores 0 SB, 1 SH, 2 SW.
ReqAddr  in  32  byte address from the ALU.
ReqWrData  in  32  store data (rs2).
RespValid  out  1  one-cycle pulse; request complete.
RespErr  out  1  valid with RespValid; misaligned or illegal funct3.
LoadData  out  32  formatted load result; held until the next response.
MemWrEn  out  1  data memory write enable.
MemAddr  out  MEM_ADDR_BITS  data memory word address.
MemWrData  out  32  data memory write data.
MemRdData  in  32  data memory read data; synchronous, valid the cycle after the address.

Behaviour:
Reset values:
- State IDLE; RespValid=0, RespErr=0, LoadData=0, MemWrEn=0, MemWrData=0.
- MemWrEn is also gated combinationally by !Reset.

Acceptance:
- A request is accepted on a cycle where ReqValid && ReqReady (cycle T).
- Addr, funct3, store flag and data are captured at the T edge.
- ReqValid while not ready is ignored, not queued; the core must hold the request.

Addressing:
- Word index = ReqAddr[MEM_ADDR_BITS+1:2]; upper address bits are ignored (addresses wrap).
- Byte lane = Addr[1:0].
- MemAddr is combinational from ReqAddr in IDLE and from the captured address in all other states. The read is therefore issued in cycle T.

States:
- IDLE: on accept, go to ERR (illegal), LD_WAIT (load), ST_WR (SW) or ST_RD (SB/SH).
- LD_WAIT (T+1): select byte/half/word from MemRdData, extend per funct3, register into LoadData; go to RESP.
- ST_RD (T+1): merge store data into the MemRdData lane and register the result as MemWrData.
  - SB replaces byte Addr[1:0].
  - SH replaces half Addr[1].
  - Go to ST_WR.
- ST_WR: MemWrEn=1 for exactly this cycle; MemWrData is the merged word (SW: ReqWrData unchanged); go to RESP.
- RESP: RespValid=1, RespErr=0; go to IDLE. LoadData=0 for stores.
- ERR (T+1): RespValid=1, RespErr=1, LoadData=0, no memory write; go to IDLE.

Latency (RespValid cycle):
- Load: T+2.
- SW: T+2 (write at T+1).
- SB/SH: T+3 (write at T+2).
- Error: T+1.
- Next accept is possible the cycle after RESP/ERR.

Error conditions:
- LH/LHU/SH with Addr[0]=1.
- LW/SW with Addr[1:0]≠0.
- Load funct3 ∈ {3,6,7}.
- Store funct3 > 2.

Reset mid-operation:
- State returns to IDLE at the next edge; no pending write is issued and no RespValid is produced.
- Memory contents are unchanged unless the ST_WR cycle had already completed.

Simultaneous events: Reset dominates ReqValid.

Test Plan:
1. Preload byte address 0x10 = 0x8899AABB. LB 0x11 → LoadData 0xFFFFFFAA at T+2; LBU 0x11 → 0x000000AA; LB 0x10 → 0xFFFFFFBB.
2. Same word: LH 0x12 → 0xFFFF8899; LHU 0x12 → 0x00008899; LW 0x10 → 0x8899AABB. RespErr=0 and MemWrEn never high.
3. SB 0x13 with data 0x12345677 → MemWrEn high only at T+2, word = 0x7799AABB, RespValid at T+3. Then SH 0x10 with 0x0000CAFE → word 0x7799CAFE.
4. SW 0x20 with 0xDEADBEEF → MemWrEn at T+1, MemAddr=8, RespValid at T+2; LW 0x20 returns 0xDEADBEEF.
5. Error cases, each → RespValid and RespErr at T+1, LoadData=0, no MemWrEn, memory unchanged:
   - LW 0x22
   - SH 0x15
   - load funct3=3
   - store funct3=4
6. Reset asserted during ST_RD of SB 0x10 → no MemWrEn, no RespValid, word unchanged, ReqReady=1 the cycle after Reset deasserts.
7. ReqValid held high with a new request during a busy SB → the new request is accepted only on the first IDLE cycle after RESP.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the core datapath and a single-port, whole-word data memory.
// Loads are sign/zero extended. Sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int MEM_ADDR_BITS = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     ReqStore,
  input  logic [2:0]               ReqFunct3,
  input  logic [31:0]              ReqAddr,
  input  logic [DATA_WIDTH-1:0]    ReqWrData,
  output logic                     RespValid,
  output logic                     RespErr,
  output logic [DATA_WIDTH-1:0]    LoadData,
  output logic                     MemWrEn,
  output logic [MEM_ADDR_BITS-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0]    MemWrData,
  input  logic [DATA_WIDTH-1:0]    MemRdData
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LD_WAIT = 3'd1;
  localparam logic [2:0] ST_ST_RD   = 3'd2;
  localparam logic [2:0] ST_ST_WR   = 3'd3;
  localparam logic [2:0] ST_RESP    = 3'd4;
  localparam logic [2:0] ST_ERR     = 3'd5;

  localparam int AW = MEM_ADDR_BITS + 2;

  // Handshake: a request is taken on a rising edge where ReqValid && ReqReady;
  // ReqReady is high only in IDLE and the core must hold ReqValid until then.
  // RespValid is a single-cycle pulse; RespErr and LoadData qualify it.

  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

  logic                  req_illegal;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_fmt;
  logic [DATA_WIDTH-1:0] merged;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^ReqAddr[31:AW];

  always_comb begin
    req_illegal = 1'b0;
    if (ReqStore) begin
      if (ReqFunct3 > 3'd2)                              req_illegal = 1'b1;
      else if (ReqFunct3 == 3'd1 && ReqAddr[0])          req_illegal = 1'b1;
      else if (ReqFunct3 == 3'd2 && ReqAddr[1:0] != 2'b00) req_illegal = 1'b1;
    end else begin
      case (ReqFunct3)
        3'd3, 3'd6, 3'd7: req_illegal = 1'b1;
        3'd1, 3'd5:       req_illegal = ReqAddr[0];
        3'd2:             req_illegal = (ReqAddr[1:0] != 2'b00);
        default:          req_illegal = 1'b0;
      endcase
    end
  end

  // Lane extraction for loads, using the captured byte offset.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_byte = MemRdData[7:0];
      2'd1:    lane_byte = MemRdData[15:8];
      2'd2:    lane_byte = MemRdData[23:16];
      default: lane_byte = MemRdData[31:24];
    endcase
    lane_half = addr_q[1] ? MemRdData[31:16] : MemRdData[15:0];
    case (funct3_q)
      3'd0:    load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_fmt = {{16{lane_half[15]}}, lane_half};
      3'd2:    load_fmt = MemRdData;
      3'd4:    load_fmt = {24'd0, lane_byte};
      3'd5:    load_fmt = {16'd0, lane_half};
      default: load_fmt = '0;
    endcase
  end

  // Merge the store data into the word just read back (SB/SH only reach here).
  always_comb begin
    merged = MemRdData;
    if (funct3_q[1:0] == 2'd0) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    funct3_d      = funct3_q;
    wdata_d       = wdata_q;
    load_data_d   = load_data_q;
    mem_wr_data_d = mem_wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          addr_d   = ReqAddr[AW-1:0];
          funct3_d = ReqFunct3;
          wdata_d  = ReqWrData;
          if (req_illegal) begin
            state_d     = ST_ERR;
            load_data_d = '0;
          end else if (!ReqStore) begin
            state_d = ST_LD_WAIT;
          end else if (ReqFunct3 == 3'd2) begin
            state_d       = ST_ST_WR;
            mem_wr_data_d = ReqWrData;
          end else begin
            state_d = ST_ST_RD;
          end
        end
      end
      ST_LD_WAIT: begin
        load_data_d = load_fmt;
        state_d     = ST_RESP;
      end
      ST_ST_RD: begin
        mem_wr_data_d = merged;
        state_d       = ST_ST_WR;
      end
      ST_ST_WR: begin
        load_data_d = '0;
        state_d     = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      funct3_q      <= '0;
      wdata_q       <= '0;
      load_data_q   <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      funct3_q      <= funct3_d;
      wdata_q       <= wdata_d;
      load_data_q   <= load_data_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  // The read is issued in the accept cycle, so IDLE addresses memory straight from the ALU.
  assign MemAddr   = (state_q == ST_IDLE) ? ReqAddr[AW-1:2] : addr_q[AW-1:2];
  assign ReqReady  = (state_q == ST_IDLE);
  assign MemWrEn   = (state_q == ST_ST_WR) && !Reset;
  assign RespValid = ((state_q == ST_RESP) || (state_q == ST_ERR)) && !Reset;
  assign RespErr   = (state_q == ST_ERR) && !Reset;
  assign LoadData  = load_data_q;
  assign MemWrData = mem_wr_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, hand-written reset/back-pressure
// sequences, and random requests checked against a byte-level memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqStore = 1'b0;
  logic [2:0]  ReqFunct3 = 3'd0;
  logic [31:0] ReqAddr = 32'd0;
  logic [31:0] ReqWrData = 32'd0;
  logic        RespValid, RespErr;
  logic [31:0] LoadData;
  logic        MemWrEn;
  logic [8:0]  MemAddr;
  logic [31:0] MemWrData;
  logic [31:0] MemRdData;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_ADDR_BITS(9), .DATA_WIDTH(32)) dut (
    .clk(clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqStore(ReqStore), .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr),
    .ReqWrData(ReqWrData), .RespValid(RespValid), .RespErr(RespErr),
    .LoadData(LoadData), .MemWrEn(MemWrEn), .MemAddr(MemAddr),
    .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  // Synchronous single-port memory; init port used only during reset.
  logic [31:0] mem [0:511];
  logic        init_en = 1'b0;
  logic [8:0]  init_idx = 9'd0;
  logic [31:0] init_data = 32'd0;
  always @(posedge clk) begin
    if (init_en) mem[init_idx] <= init_data;
    else if (MemWrEn) mem[MemAddr] <= MemWrData;
    MemRdData <= mem[MemAddr];
  end

  logic [31:0] ref_mem [0:511];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Issue one request and check it against the byte-level model.
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] o_ld, output logic o_err);
    logic ill;
    int idx, sh, exp_lat, exp_wr, resp_k, wr_k, wait_k;
    logic [31:0] w, v, mask, exp_ld, exp_word, wr_data;
    logic [8:0] wr_addr;
    o_ld = 32'hx; o_err = 1'bx;
    idx = int'(a[10:2]);
    sh = 8 * int'(a[1:0]);
    w = ref_mem[idx];
    if (st) ill = (f3 > 3'd2) || (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    else    ill = (f3 == 3'd3) || (f3 >= 3'd6) || ((f3 == 3'd1 || f3 == 3'd5) && a[0]) ||
                  (f3 == 3'd2 && a[1:0] != 2'b00);
    exp_ld = 32'd0; exp_word = w; exp_wr = 0;
    if (ill) exp_lat = 1;
    else if (!st) begin
      exp_lat = 2;
      v = w >> sh;
      if (f3 == 3'd0 || f3 == 3'd4) begin
        v = v & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
      end else if (f3 == 3'd1 || f3 == 3'd5) begin
        v = v & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      end
      exp_ld = v;
    end else begin
      mask = ((f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF) << sh;
      exp_word = (w & ~mask) | ((wd << sh) & mask);
      exp_wr = (f3 == 3'd2) ? 1 : 2;
      exp_lat = exp_wr + 1;
    end

    @(negedge clk);
    ReqStore = st; ReqFunct3 = f3; ReqAddr = a; ReqWrData = wd; ReqValid = 1'b1;
    wait_k = 0;
    while (!ReqReady && wait_k < 16) begin
      @(negedge clk);
      wait_k++;
    end
    if (!ReqReady) begin
      chk("accept_timeout", 32'(ReqReady), 32'd1);
      ReqValid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 ReqValid = 1'b0;
    resp_k = 0; wr_k = 0; wr_addr = 9'd0; wr_data = 32'd0;
    for (int k = 1; k <= 8 && resp_k == 0; k++) begin
      @(negedge clk);
      if (MemWrEn) begin
        if (wr_k == 0) begin wr_k = k; wr_addr = MemAddr; wr_data = MemWrData; end
        else wr_k = 99;
      end
      if (RespValid) begin resp_k = k; o_err = RespErr; o_ld = LoadData; end
    end
    chk("resp_latency", 32'(resp_k), 32'(exp_lat));
    if (resp_k == 0) return;
    chk("resp_err", 32'(o_err), 32'(ill));
    chk("load_data", o_ld, exp_ld);
    chk("write_cycle", 32'(wr_k), 32'(exp_wr));
    if (exp_wr != 0) begin
      chk("write_addr", 32'(wr_addr), 32'(idx));
      chk("write_data", wr_data, exp_word);
    end
    @(negedge clk);
    chk("resp_pulse", 32'(RespValid), 32'd0);
    ref_mem[idx] = exp_word;
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [31:0] o_ld;
    logic o_err;
    int resp1, resp2, acc2, wr_seen, rv_seen;
    logic [31:0] ld2;

    vecs.push_back('{1'b0, 3'd0, 32'h11, 32'h0, 1'b0, 32'hFFFFFFAA});
    vecs.push_back('{1'b0, 3'd4, 32'h11, 32'h0, 1'b0, 32'h000000AA});
    vecs.push_back('{1'b0, 3'd0, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB});
    vecs.push_back('{1'b0, 3'd1, 32'h12, 32'h0, 1'b0, 32'hFFFF8899});
    vecs.push_back('{1'b0, 3'd5, 32'h12, 32'h0, 1'b0, 32'h00008899});
    vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h8899AABB});
    vecs.push_back('{1'b1, 3'd0, 32'h13, 32'h12345677, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h7799AABB});
    vecs.push_back('{1'b1, 3'd1, 32'h10, 32'h0000CAFE, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h7799CAFE});
    vecs.push_back('{1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h20, 32'h0, 1'b0, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 3'd2, 32'h22, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'h15, 32'h0000BEEF, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 3'd4, 32'h10, 32'h11111111, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h7799CAFE});

    // Reset, memory initialisation, reset-state checks.
    init_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      init_idx = 9'(i);
      init_data = (i == 4) ? 32'h8899AABB : 32'd0;
      ref_mem[i] = init_data;
    end
    @(negedge clk);
    init_en = 1'b0;
    chk("rst_resp_valid", 32'(RespValid), 32'd0);
    chk("rst_resp_err", 32'(RespErr), 32'd0);
    chk("rst_load_data", LoadData, 32'd0);
    chk("rst_mem_wr_en", 32'(MemWrEn), 32'd0);
    chk("rst_mem_wr_data", MemWrData, 32'd0);
    Reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(ReqReady), 32'd1);

    // Directed table.
    foreach (vecs[i]) begin
      run_req(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, o_ld, o_err);
      chk($sformatf("vec%0d_err", i), 32'(o_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ld", i), o_ld, vecs[i].exp_ld);
    end

    // Reset while the SB is in its read phase: nothing written, no response.
    @(negedge clk);
    ReqStore = 1'b1; ReqFunct3 = 3'd0; ReqAddr = 32'h10; ReqWrData = 32'h000000EE; ReqValid = 1'b1;
    @(posedge clk);
    #1 ReqValid = 1'b0; Reset = 1'b1;
    wr_seen = 0; rv_seen = 0;
    @(negedge clk);
    if (MemWrEn) wr_seen++;
    if (RespValid) rv_seen++;
    @(posedge clk);
    #1 Reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(ReqReady), 32'd1);
    for (int k = 0; k < 4; k++) begin
      if (MemWrEn) wr_seen++;
      if (RespValid) rv_seen++;
      @(negedge clk);
    end
    chk("midrst_no_write", 32'(wr_seen), 32'd0);
    chk("midrst_no_resp", 32'(rv_seen), 32'd0);
    chk("midrst_mem", mem[4], 32'h7799CAFE);

    // A request held during a busy SB is accepted only after RESP.
    @(negedge clk);
    ReqStore = 1'b1; ReqFunct3 = 3'd0; ReqAddr = 32'h21; ReqWrData = 32'h00000055; ReqValid = 1'b1;
    @(posedge clk);
    #1 ReqStore = 1'b0; ReqFunct3 = 3'd2; ReqAddr = 32'h20; ReqWrData = 32'd0;
    resp1 = 0; resp2 = 0; acc2 = 0; ld2 = 32'd0;
    for (int k = 1; k <= 10 && resp2 == 0; k++) begin
      @(negedge clk);
      if (RespValid) begin
        if (resp1 == 0) resp1 = k;
        else begin resp2 = k; ld2 = LoadData; end
      end
      if (ReqReady && acc2 == 0) begin
        acc2 = k;
        @(posedge clk);
        #1 ReqValid = 1'b0;
      end
    end
    ReqValid = 1'b0;
    ref_mem[8] = 32'hDEAD55EF;
    chk("busy_sb_resp", 32'(resp1), 32'd3);
    chk("busy_accept", 32'(acc2), 32'd4);
    chk("busy_lw_resp", 32'(resp2), 32'd6);
    chk("busy_lw_data", ld2, ref_mem[8]);

    // Random requests; upper address bits vary to exercise wrap-around.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFFF83F;
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, o_ld, o_err);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
